// File: rtl/burst_meter_pkg.sv
// Shared types and default widths for the burst-length meter.
package burst_meter_pkg;

   localparam int LEN_W_DEF = 8;
   localparam int CNT_W_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/burst_meter_hold.sv
// Single-entry result holding register with valid/ready handshake and overflow drop pulse.
module burst_meter_hold #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W:0]   data,
   input  logic             ready,
   output logic             valid,
   output logic [LEN_W:0]   q,
   output logic             drop
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
         drop  <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (load) begin
            // A result leaving on this edge frees the slot for the new one.
            if (!valid || ready) begin
               q     <= data;
               valid <= 1'b1;
            end else begin
               drop <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/burst_meter.sv
// Measures the length of runs on r (terminated by f) and offers each length downstream.
// Optional statistics counters are compiled in with BURST_METER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a run to start (r=1)
// RUN   | counting r cycles until the f end-of-run pulse
module burst_meter
   import burst_meter_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r,
   input  logic             f,
   output logic [LEN_W-1:0] len,
   output logic             len_sat,
   output logic             len_valid,
   input  logic             len_ready,
   output logic             drop,
   output logic             proto_err
`ifdef BURST_METER_STATS_EN
   ,
   output logic [CNT_W-1:0] burst_cnt,
   output logic [CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic             sat, sat_nxt;
   logic             perr_nxt;
   logic             load;
   logic [LEN_W:0]   hold_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sat       <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         sat       <= sat_nxt;
         proto_err <= perr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sat_nxt   = sat;
      perr_nxt  = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (f) begin
               perr_nxt = 1'b1;
            end else if (r) begin
               state_nxt = RUN;
               cnt_nxt   = LEN_W'(1);
               sat_nxt   = 1'b0;
            end
         end
         RUN: begin
            case ({r, f})
               2'b10: begin
                  // sat marks a run longer than len can represent
                  if (cnt == CNT_MAX) sat_nxt = 1'b1;
                  else                cnt_nxt = cnt + LEN_W'(1);
               end
               2'b01: begin
                  load      = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  sat_nxt   = 1'b0;
               end
               default: begin
                  perr_nxt  = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  sat_nxt   = 1'b0;
               end
            endcase
         end
         default: state_nxt = IDLE;
      endcase
   end

   burst_meter_hold #(
      .LEN_W (LEN_W)
   ) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .data  ({sat, cnt}),
      .ready (len_ready),
      .valid (len_valid),
      .q     (hold_q),
      .drop  (drop)
   );

   assign len     = hold_q[LEN_W-1:0];
   assign len_sat = hold_q[LEN_W];

`ifdef BURST_METER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (len_valid && len_ready) burst_cnt <= burst_cnt + CNT_W'(1);
         if (drop)                   drop_cnt  <= drop_cnt + CNT_W'(1);
      end
   end
`endif

`ifndef SYNTHESIS
   function automatic string state_name(state_t s);
      case (s)
         IDLE:    return "IDLE";
         RUN:     return "RUN";
         default: return "UNKNOWN";
      endcase
   endfunction
`endif

endmodule

// File: tb/tb_burst_meter.sv
// Directed self-checking bench for burst_meter (8-bit and 4-bit length instances).
module tb_burst_meter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       r, f, rdy;
   logic [7:0] len;
   logic       len_sat, len_valid, drop, proto_err;
   logic [3:0] len4;
   logic       len_sat4, len_valid4, drop4, proto_err4;
`ifdef BURST_METER_STATS_EN
   logic [15:0] bcnt, dcnt, bcnt4, dcnt4;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   burst_meter #(.LEN_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r         (r),
      .f         (f),
      .len       (len),
      .len_sat   (len_sat),
      .len_valid (len_valid),
      .len_ready (rdy),
      .drop      (drop),
      .proto_err (proto_err)
`ifdef BURST_METER_STATS_EN
      ,
      .burst_cnt (bcnt),
      .drop_cnt  (dcnt)
`endif
   );

   burst_meter #(.LEN_W(4), .CNT_W(16)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .r         (r),
      .f         (f),
      .len       (len4),
      .len_sat   (len_sat4),
      .len_valid (len_valid4),
      .len_ready (rdy),
      .drop      (drop4),
      .proto_err (proto_err4)
`ifdef BURST_METER_STATS_EN
      ,
      .burst_cnt (bcnt4),
      .drop_cnt  (dcnt4)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // r high for n cycles, then a one-cycle f; returns just after the capture edge
   task automatic run(input int n);
      r = 1'b1;
      repeat (n) tick();
      r = 1'b0;
      f = 1'b1;
      tick();
      f = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; r = 1'b0; f = 1'b0; rdy = 1'b0;
      tick();
      tick();
      tot_cnt++;
      if ({len, len_sat, len_valid, drop, proto_err} !== 12'h000)
         $display("FAIL reset_outputs: got len=%0d sat=%b valid=%b drop=%b perr=%b, want all 0",
                  len, len_sat, len_valid, drop, proto_err);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      rdy = 1'b1;
      run(5);
      tot_cnt++;
      if ({len_valid, len_sat, len} !== {1'b1, 1'b0, 8'd5})
         $display("FAIL basic_len: got valid=%b sat=%b len=%0d, want valid=1 sat=0 len=5",
                  len_valid, len_sat, len);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (len_valid !== 1'b0)
         $display("FAIL basic_valid_one_cycle: got valid=%b, want 0", len_valid);
      else pass_cnt++;
   endtask

   task automatic test_sat();
      rdy = 1'b1;
      run(20);
      tot_cnt++;
      if ({len_valid4, len_sat4, len4} !== {1'b1, 1'b1, 4'd15})
         $display("FAIL sat_len4: got valid=%b sat=%b len=%0d, want valid=1 sat=1 len=15",
                  len_valid4, len_sat4, len4);
      else pass_cnt++;
      tot_cnt++;
      if ({len_sat, len} !== {1'b0, 8'd20})
         $display("FAIL sat_len8: got sat=%b len=%0d, want sat=0 len=20", len_sat, len);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_drop();
      rdy = 1'b0;
      run(3);
      tot_cnt++;
      if ({len_valid, len} !== {1'b1, 8'd3})
         $display("FAIL drop_first: got valid=%b len=%0d, want valid=1 len=3", len_valid, len);
      else pass_cnt++;
      run(7);
      tot_cnt++;
      if ({len_valid, len, drop} !== {1'b1, 8'd3, 1'b1})
         $display("FAIL drop_pulse: got valid=%b len=%0d drop=%b, want valid=1 len=3 drop=1",
                  len_valid, len, drop);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if ({drop, len} !== {1'b0, 8'd3})
         $display("FAIL drop_single: got drop=%b len=%0d, want drop=0 len=3", drop, len);
      else pass_cnt++;
      rdy = 1'b1;
      tick();
      tot_cnt++;
      if (len_valid !== 1'b0)
         $display("FAIL drop_transfer: got valid=%b, want 0", len_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      rdy = 1'b0;
      run(2);
      tot_cnt++;
      if ({len_valid, len} !== {1'b1, 8'd2})
         $display("FAIL b2b_first: got valid=%b len=%0d, want valid=1 len=2", len_valid, len);
      else pass_cnt++;
      r = 1'b1;
      repeat (4) tick();
      r = 1'b0; f = 1'b1; rdy = 1'b1;
      tick();
      f = 1'b0; rdy = 1'b0;
      tot_cnt++;
      if ({len_valid, len, drop} !== {1'b1, 8'd4, 1'b0})
         $display("FAIL b2b_replace: got valid=%b len=%0d drop=%b, want valid=1 len=4 drop=0",
                  len_valid, len, drop);
      else pass_cnt++;
      rdy = 1'b1;
      tick();
      tot_cnt++;
      if (len_valid !== 1'b0)
         $display("FAIL b2b_drain: got valid=%b, want 0", len_valid);
      else pass_cnt++;
   endtask

   task automatic test_proto();
      rdy = 1'b1;
      f = 1'b1;
      tick();
      f = 1'b0;
      tot_cnt++;
      if ({proto_err, len_valid} !== 2'b10)
         $display("FAIL proto_idle_f: got perr=%b valid=%b, want perr=1 valid=0", proto_err, len_valid);
      else pass_cnt++;
      r = 1'b1;
      tick();
      tot_cnt++;
      if (proto_err !== 1'b0)
         $display("FAIL proto_pulse_width: got perr=%b, want 0", proto_err);
      else pass_cnt++;
      f = 1'b1;
      tick();
      f = 1'b0;
      tot_cnt++;
      if ({proto_err, len_valid} !== 2'b10)
         $display("FAIL proto_run_rf: got perr=%b valid=%b, want perr=1 valid=0", proto_err, len_valid);
      else pass_cnt++;
      tick();
      r = 1'b0;
      tick();
      tot_cnt++;
      if ({proto_err, len_valid} !== 2'b10)
         $display("FAIL proto_run_none: got perr=%b valid=%b, want perr=1 valid=0", proto_err, len_valid);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid();
      rdy = 1'b0;
      run(2);
      r = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      r = 1'b0;
      tot_cnt++;
      if ({len, len_sat, len_valid, drop, proto_err} !== 12'h000)
         $display("FAIL rstmid_outputs: got len=%0d sat=%b valid=%b drop=%b perr=%b, want all 0",
                  len, len_sat, len_valid, drop, proto_err);
      else pass_cnt++;
`ifdef BURST_METER_STATS_EN
      tot_cnt++;
      if ({bcnt, dcnt} !== 32'h0)
         $display("FAIL rstmid_stats: got burst_cnt=%0d drop_cnt=%0d, want 0 0", bcnt, dcnt);
      else pass_cnt++;
`endif
      rst_n = 1'b1;
      rdy = 1'b1;
      run(2);
      tot_cnt++;
      if ({len_valid, len, drop, proto_err} !== {1'b1, 8'd2, 1'b0, 1'b0})
         $display("FAIL rstmid_rerun: got valid=%b len=%0d drop=%b perr=%b, want valid=1 len=2 drop=0 perr=0",
                  len_valid, len, drop, proto_err);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (len_valid !== 1'b0)
         $display("FAIL rstmid_drain: got valid=%b, want 0", len_valid);
      else pass_cnt++;
`ifdef BURST_METER_STATS_EN
      tot_cnt++;
      if (bcnt !== 16'd1)
         $display("FAIL rstmid_burst_cnt: got %0d, want 1", bcnt);
      else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sat();
      test_drop();
      test_back_to_back();
      test_proto();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/burst_meter.md
BURST_METER -- requirements
Module: burst_meter

Interface
REQ-001 The module SHALL expose parameter LEN_W, default 8, which is the width of the burst-length result.
REQ-002 The module SHALL expose parameter CNT_W, default 16, which is the width of the statistics counters (used only when stats are compiled in).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port r, input, 1 bit: run indication from the upstream edge FSM, high on every cycle of a run.
REQ-006 Port f, input, 1 bit: single-cycle end-of-run pulse from the upstream FSM, arriving in the cycle after r falls.
REQ-007 Port len, output, LEN_W bits: the measured run length (number of r cycles).
REQ-008 Port len_sat, output, 1 bit: the held len saturated at 2^LEN_W-1.
REQ-009 Port len_valid, output, 1 bit: a result is held and offered downstream.
REQ-010 Port len_ready, input, 1 bit: the downstream accepts the result.
REQ-011 Port drop, output, 1 bit: one-cycle pulse when a completed result is discarded because the holding register is full.
REQ-012 Port proto_err, output, 1 bit: one-cycle pulse when an illegal r/f sequence is seen.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and RUN, and all outputs SHALL be registered.
REQ-014 In IDLE with r=1 and f=0, the FSM SHALL move to RUN and load cnt=1.
REQ-015 In IDLE with f=1 (with any value of r), the block SHALL pulse proto_err, stay in IDLE, and capture nothing.
REQ-016 In RUN with r=1 and f=0, the block SHALL increment cnt, saturating at 2^LEN_W-1 and setting the internal sat flag.
REQ-017 In RUN with r=0 and f=1, the block SHALL capture {cnt, sat} into the holding register, go to IDLE, and clear cnt and sat.
REQ-018 In RUN with r=0 and f=0, or with r=1 and f=1, the block SHALL pulse proto_err, discard cnt, and go to IDLE.
REQ-019 A capture SHALL drive len, len_sat and len_valid=1 in the cycle after the edge on which f was sampled (latency 1).
REQ-020 The handshake SHALL complete on a clock edge where len_valid=1 and len_ready=1; with no simultaneous capture, len_valid SHALL drop on the next cycle.
REQ-021 While len_valid=1, len and len_sat SHALL remain stable until the transfer completes.
REQ-022 On a capture while len_valid=1 and len_ready=0, the block SHALL keep the old result and pulse drop one cycle later.
REQ-023 On a capture while len_valid=1 and len_ready=1, the block SHALL load the new result, keep len_valid=1, and not pulse drop.
REQ-024 len_ready SHALL have no effect while len_valid=0.

Reset
REQ-025 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, cnt=0, sat=0, len=0, len_sat=0, len_valid=0, drop=0, proto_err=0, and clear the stats counters.
REQ-026 A reset asserted mid-run or with a result pending SHALL discard all data without pulsing drop or proto_err.
REQ-027 On the first edge after rst_n rises, the block SHALL treat r=1 as a run start.

Configuration
REQ-028 When BURST_METER_STATS_EN is defined, the block SHALL add outputs burst_cnt[CNT_W-1:0] (accepted handshakes) and drop_cnt[CNT_W-1:0] (drop pulses), both wrapping modulo 2^CNT_W.
REQ-029 When BURST_METER_STATS_EN is undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package burst_meter_pkg SHALL hold the state encoding (IDLE=1'b0, RUN=1'b1) and the default values of LEN_W and CNT_W.
REQ-031 The holding register and handshake logic SHALL be sub-module burst_meter_hold, parameterised by LEN_W, with inputs load, data, ready and outputs valid, q, drop.
REQ-032 The block SHALL include a simulation-only state-name decode, excluded under SYNTHESIS.

Verification
REQ-033 Stimulus: r high for 5 cycles, then an f pulse, with len_ready=1 → len=5, len_sat=0, len_valid high for exactly 1 cycle.
REQ-034 Stimulus: LEN_W=4, r high for 20 cycles, then f → len=15, len_sat=1.
REQ-035 Stimulus: two runs of 3 and 7 with len_ready=0 → len stays 3, drop pulses once; then len_ready=1 → transfer of 3, and len_valid goes low.
REQ-036 Stimulus: a capture of run 4 in the same cycle as a handshake of the previous run 2 → len=4, len_valid stays 1, no drop.
REQ-037 Stimulus: f in IDLE; then r=1,f=1 in RUN; then r=0,f=0 in RUN → three proto_err pulses, no len_valid.
REQ-038 Stimulus: rst_n=0 during the 3rd cycle of a run, with a result pending → all outputs are 0 after the edge; a following run of 2 gives len=2; with BURST_METER_STATS_EN defined, burst_cnt=1.
